// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Purpose:
//   Hazard and exception control for a five-stage Y86-style pipeline. Decides,
//   each cycle, which stage registers hold (stall) and which receive a nop
//   (bubble). It also tracks data-memory wait states, times out a stuck
//   memory, and latches a sticky halt.
//
// Parameters:
//   REG_W        register-ID width; the all-ones ID means "no register"
//   MEM_WAIT_MAX busy cycles tolerated before a memory timeout (1..255)
//   CNT_W        performance-counter width
//
// Ports:
//   clk, rst                      clock (rising edge), async active-high reset
//   D_icode, E_icode, M_icode     instruction codes in decode/execute/memory
//   d_srcA, d_srcB                source registers read in decode
//   E_dstM                        load destination held in execute
//   e_Cnd                         branch condition for the jump in execute
//   m_stat, W_stat                stage status (0 = AOK)
//   mem_busy                      data memory not ready this cycle
//   F/D/E/M/W_stall               hold the stage register
//   D/E/M/W_bubble                load a nop into the stage register
//   set_cc                        condition-code write enable
//   halted                        sticky halt indicator
//   mem_timeout                   sticky memory-timeout flag
//   loaduse_cnt, mispredict_cnt   performance counters
//
// Configuration:
//   PIPE_HZD_PERF_EN  when defined, the two performance counters count cycles
//                     in which load-use (resp. mispredict) is the winning
//                     hazard, saturating at all-ones. When undefined the
//                     counter ports are tied to zero.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int REG_W        = 4,
  parameter int MEM_WAIT_MAX = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       M_icode,
  input  logic [REG_W-1:0] d_srcA,
  input  logic [REG_W-1:0] d_srcB,
  input  logic [REG_W-1:0] E_dstM,
  input  logic             e_Cnd,
  input  logic [1:0]       m_stat,
  input  logic [1:0]       W_stat,
  input  logic             mem_busy,
  output logic             F_stall,
  output logic             D_stall,
  output logic             E_stall,
  output logic             M_stall,
  output logic             W_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_bubble,
  output logic             set_cc,
  output logic             halted,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] loaduse_cnt,
  output logic [CNT_W-1:0] mispredict_cnt
);

  localparam logic [3:0] I_RMMOVQ = 4'd4;
  localparam logic [3:0] I_MRMOVQ = 4'd5;
  localparam logic [3:0] I_OPQ    = 4'd6;
  localparam logic [3:0] I_JXX    = 4'd7;
  localparam logic [3:0] I_CALL   = 4'd8;
  localparam logic [3:0] I_RET    = 4'd9;
  localparam logic [3:0] I_PUSHQ  = 4'd10;
  localparam logic [3:0] I_POPQ   = 4'd11;

  localparam logic [REG_W-1:0] RNONE      = '1;
  localparam logic [7:0]       WAIT_LIMIT = 8'(MEM_WAIT_MAX);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    HALT    = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [7:0] wait_cnt;

  logic memop;
  logic memstall;
  logic loaduse;
  logic mispredict;
  logic retpend;
  logic exc;
  logic timeout;

  // Hazard condition decode
  always_comb begin
    memop = (M_icode == I_RMMOVQ) || (M_icode == I_MRMOVQ) ||
            (M_icode == I_CALL)   || (M_icode == I_RET)    ||
            (M_icode == I_PUSHQ)  || (M_icode == I_POPQ);
    // Once halted the memory interface is ignored entirely, so a busy memory
    // can neither stall a halted pipe nor push it toward a timeout.
    memstall   = memop && mem_busy && (state != HALT);
    loaduse    = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) &&
                 (E_dstM != RNONE) &&
                 ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    mispredict = (E_icode == I_JXX) && !e_Cnd;
    retpend    = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
    exc        = (m_stat != 2'd0) || (W_stat != 2'd0);
    timeout    = memstall && (wait_cnt == WAIT_LIMIT);
  end

  // Stall/bubble outputs by priority. Exceptions do not mask the lower-priority
  // hazards: they only add the memory/writeback controls on top of them.
  always_comb begin
    F_stall  = 1'b0;
    D_stall  = 1'b0;
    E_stall  = 1'b0;
    M_stall  = 1'b0;
    W_stall  = 1'b0;
    D_bubble = 1'b0;
    E_bubble = 1'b0;
    M_bubble = 1'b0;
    W_bubble = 1'b0;
    if (state == HALT) begin
      F_stall  = 1'b1;
      D_stall  = 1'b1;
      E_stall  = 1'b1;
      M_bubble = 1'b1;
      W_stall  = 1'b1;
    end else if (memstall) begin
      F_stall  = 1'b1;
      D_stall  = 1'b1;
      E_stall  = 1'b1;
      M_stall  = 1'b1;
      W_bubble = 1'b1;
    end else begin
      if (exc) begin
        M_bubble = 1'b1;
        W_stall  = (W_stat != 2'd0);
      end
      // A pending return is held off behind the load-use stall; bubbling
      // decode here would throw away the stalled instruction.
      if (loaduse) begin
        F_stall  = 1'b1;
        D_stall  = 1'b1;
        E_bubble = 1'b1;
      end else if (mispredict) begin
        D_bubble = 1'b1;
        E_bubble = 1'b1;
        F_stall  = retpend;
      end else if (retpend) begin
        F_stall  = 1'b1;
        D_bubble = 1'b1;
      end
    end
  end

  assign set_cc = (E_icode == I_OPQ) && !exc && !memstall && (state == RUN);
  assign halted = (state == HALT);

  // Next-state logic. A writeback exception or a memory timeout overrides
  // everything; both together still produce a single entry into HALT.
  always_comb begin
    state_next = state;
    unique case (state)
      RUN:     if (memstall) state_next = MEMWAIT;
      MEMWAIT: if (!memstall) state_next = RUN;
      HALT:    state_next = HALT;
      default: state_next = RUN;
    endcase
    if ((W_stat != 2'd0) || timeout) state_next = HALT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      wait_cnt    <= 8'd0;
      mem_timeout <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= memstall ? (wait_cnt + 8'd1) : 8'd0;
      if (timeout) mem_timeout <= 1'b1;
    end
  end

`ifdef PIPE_HZD_PERF_EN
  logic loaduse_win;
  logic mispredict_win;

  // A hazard is counted only in cycles where it is the highest-priority cause.
  assign loaduse_win    = (state != HALT) && !memstall && !exc && loaduse;
  assign mispredict_win = (state != HALT) && !memstall && !exc && !loaduse &&
                          mispredict;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loaduse_cnt    <= '0;
      mispredict_cnt <= '0;
    end else begin
      if (loaduse_win && (loaduse_cnt != '1))
        loaduse_cnt <= loaduse_cnt + CNT_W'(1);
      if (mispredict_win && (mispredict_cnt != '1))
        mispredict_cnt <= mispredict_cnt + CNT_W'(1);
    end
  end
`else
  assign loaduse_cnt    = '0;
  assign mispredict_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Purpose:
//   Self-checking bench for pipe_hazard_ctrl. Every cycle the stimulus task
//   drives the inputs, asks a behavioural model for the expected outputs and
//   pushes them onto a scoreboard queue; the entry is popped and compared once
//   the DUT outputs have settled. The DUT uses CNT_W=2 so counter saturation
//   is reachable; counter expectations follow PIPE_HZD_PERF_EN.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam int REG_W        = 4;
  localparam int MEM_WAIT_MAX = 3;
  localparam int CNT_W        = 2;
  localparam int CNT_MAX      = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       D_icode, E_icode, M_icode;
  logic [REG_W-1:0] d_srcA, d_srcB, E_dstM;
  logic             e_Cnd;
  logic [1:0]       m_stat, W_stat;
  logic             mem_busy;
  logic             F_stall, D_stall, E_stall, M_stall, W_stall;
  logic             D_bubble, E_bubble, M_bubble, W_bubble;
  logic             set_cc, halted, mem_timeout;
  logic [CNT_W-1:0] loaduse_cnt, mispredict_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [11:0] ctl;
    logic [3:0]  cnt;
  } exp_t;

  exp_t scoreboard[$];

  // Model state: 0 = RUN, 1 = MEMWAIT, 2 = HALT
  int m_state;
  int m_wait;
  bit m_timeout;
  int m_lu;
  int m_mp;

  pipe_hazard_ctrl #(
    .REG_W(REG_W),
    .MEM_WAIT_MAX(MEM_WAIT_MAX),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .D_icode(D_icode),
    .E_icode(E_icode),
    .M_icode(M_icode),
    .d_srcA(d_srcA),
    .d_srcB(d_srcB),
    .E_dstM(E_dstM),
    .e_Cnd(e_Cnd),
    .m_stat(m_stat),
    .W_stat(W_stat),
    .mem_busy(mem_busy),
    .F_stall(F_stall),
    .D_stall(D_stall),
    .E_stall(E_stall),
    .M_stall(M_stall),
    .W_stall(W_stall),
    .D_bubble(D_bubble),
    .E_bubble(E_bubble),
    .M_bubble(M_bubble),
    .W_bubble(W_bubble),
    .set_cc(set_cc),
    .halted(halted),
    .mem_timeout(mem_timeout),
    .loaduse_cnt(loaduse_cnt),
    .mispredict_cnt(mispredict_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout expected completion");
    $fatal(1, "[TB] simulation watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic bit c_memstall();
    bit memop;
    memop = (M_icode inside {4'd4, 4'd5, 4'd8, 4'd9, 4'd10, 4'd11});
    return memop && mem_busy && (m_state != 2);
  endfunction

  function automatic bit c_loaduse();
    return (E_icode == 4'd5 || E_icode == 4'd11) && (E_dstM != 4'hF) &&
           (E_dstM == d_srcA || E_dstM == d_srcB);
  endfunction

  function automatic exp_t modelOutputs();
    exp_t e;
    bit fs, ds, es, mst, ws, db, eb, mb, wb, cc;
    bit ms, lu, mp, rp, ex;
    ms = c_memstall();
    lu = c_loaduse();
    mp = (E_icode == 4'd7) && !e_Cnd;
    rp = (D_icode == 4'd9) || (E_icode == 4'd9) || (M_icode == 4'd9);
    ex = (m_stat != 0) || (W_stat != 0);
    {fs, ds, es, mst, ws, db, eb, mb, wb} = '0;
    if (m_state == 2) begin
      {fs, ds, es, mb, ws} = 5'b11111;
    end else if (ms) begin
      {fs, ds, es, mst, wb} = 5'b11111;
    end else begin
      if (ex) begin
        mb = 1'b1;
        ws = (W_stat != 0);
      end
      if (lu) begin
        {fs, ds, eb} = 3'b111;
      end else if (mp) begin
        {db, eb} = 2'b11;
        fs = rp;
      end else if (rp) begin
        {fs, db} = 2'b11;
      end
    end
    cc = (E_icode == 4'd6) && !ex && !ms && (m_state == 0);
    e.ctl = {fs, ds, es, mst, ws, db, eb, mb, wb, cc, (m_state == 2), m_timeout};
`ifdef PIPE_HZD_PERF_EN
    e.cnt = {2'(m_lu), 2'(m_mp)};
`else
    e.cnt = 4'd0;
`endif
    return e;
  endfunction

  // Advance the model across the coming rising edge with the current inputs.
  task automatic modelStep();
    bit ms, lu, mp, ex, to;
    ms = c_memstall();
    lu = c_loaduse();
    mp = (E_icode == 4'd7) && !e_Cnd;
    ex = (m_stat != 0) || (W_stat != 0);
    to = ms && (m_wait == MEM_WAIT_MAX);
    if (to) m_timeout = 1'b1;
    if (m_state != 2 && !ms && !ex) begin
      if (lu && m_lu < CNT_MAX) m_lu++;
      if (!lu && mp && m_mp < CNT_MAX) m_mp++;
    end
    if (m_state == 2 || W_stat != 0 || to) m_state = 2;
    else if (ms) m_state = 1;
    else m_state = 0;
    m_wait = ms ? m_wait + 1 : 0;
  endtask

  task automatic modelReset();
    m_state   = 0;
    m_wait    = 0;
    m_timeout = 1'b0;
    m_lu      = 0;
    m_mp      = 0;
  endtask

  task automatic driveIdle();
    D_icode  = 4'd1;
    E_icode  = 4'd1;
    M_icode  = 4'd1;
    d_srcA   = 4'hF;
    d_srcB   = 4'hF;
    E_dstM   = 4'hF;
    e_Cnd    = 1'b0;
    m_stat   = 2'd0;
    W_stat   = 2'd0;
    mem_busy = 1'b0;
  endtask

  task automatic applyStimulus(input string tag,
                               input logic [3:0] di, input logic [3:0] ei,
                               input logic [3:0] mi, input logic [3:0] sa,
                               input logic [3:0] sbv, input logic [3:0] dm,
                               input logic cnd, input logic [1:0] mst,
                               input logic [1:0] wst, input logic busy);
    exp_t e;
    logic [11:0] ctl;
    @(negedge clk);
    D_icode  = di;
    E_icode  = ei;
    M_icode  = mi;
    d_srcA   = sa;
    d_srcB   = sbv;
    E_dstM   = dm;
    e_Cnd    = cnd;
    m_stat   = mst;
    W_stat   = wst;
    mem_busy = busy;
    scoreboard.push_back(modelOutputs());
    #2;
    e = scoreboard.pop_front();
    ctl = {F_stall, D_stall, E_stall, M_stall, W_stall, D_bubble, E_bubble,
           M_bubble, W_bubble, set_cc, halted, mem_timeout};
    checkOutput({tag, "_ctl"}, 32'(ctl), 32'(e.ctl));
    checkOutput({tag, "_cnt"}, 32'({loaduse_cnt, mispredict_cnt}), 32'(e.cnt));
    modelStep();
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    driveIdle();
    modelReset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    driveIdle();
    modelReset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    $display("[TB] reset state and idle");
    applyStimulus("idle", 1, 1, 1, 15, 15, 15, 0, 0, 0, 0);

    $display("[TB] load-use, including retpend suppression and saturation");
    for (int i = 0; i < 5; i++)
      applyStimulus("loaduse", 9, 5, 1, 3, 15, 3, 0, 0, 0, 0);
    applyStimulus("loaduse_srcB", 1, 11, 1, 15, 6, 6, 0, 0, 0, 0);
    applyStimulus("rnone_dst", 1, 5, 1, 15, 15, 15, 0, 0, 0, 0);
    applyStimulus("dst15_src3", 1, 5, 1, 3, 15, 15, 0, 0, 0, 0);

    $display("[TB] branch and return hazards");
    applyStimulus("mispred_ret", 9, 7, 1, 15, 15, 15, 0, 0, 0, 0);
    applyStimulus("taken_ret", 9, 7, 1, 15, 15, 15, 1, 0, 0, 0);
    applyStimulus("mispred", 1, 7, 1, 15, 15, 15, 0, 0, 0, 0);
    applyStimulus("ret_in_M", 1, 1, 9, 15, 15, 15, 0, 0, 0, 0);
    applyStimulus("lu_over_mp", 1, 5, 1, 2, 15, 2, 0, 0, 0, 0);

    $display("[TB] condition codes and exceptions");
    applyStimulus("opq", 1, 6, 1, 15, 15, 15, 0, 0, 0, 0);
    applyStimulus("opq_mstat", 1, 6, 1, 15, 15, 15, 0, 1, 0, 0);
    applyStimulus("exc_loaduse", 9, 5, 1, 4, 15, 4, 0, 3, 0, 0);

    $display("[TB] memory wait without timeout");
    for (int i = 0; i < MEM_WAIT_MAX; i++)
      applyStimulus("memwait", 1, 6, 5, 15, 15, 15, 0, 0, 0, 1);
    applyStimulus("memwait_release", 1, 6, 5, 15, 15, 15, 0, 0, 0, 0);
    applyStimulus("after_wait", 1, 6, 1, 15, 15, 15, 0, 0, 0, 0);

    $display("[TB] memory timeout");
    for (int i = 0; i < MEM_WAIT_MAX + 1; i++)
      applyStimulus("mem_to", 1, 1, 5, 15, 15, 15, 0, 0, 0, 1);
    applyStimulus("halt_after_to", 1, 6, 5, 15, 15, 15, 0, 0, 0, 1);
    doReset();
    applyStimulus("run_after_rst", 9, 5, 1, 3, 15, 3, 0, 0, 0, 0);

    $display("[TB] reset in the middle of a wait");
    for (int i = 0; i < MEM_WAIT_MAX - 1; i++)
      applyStimulus("wait_pre_rst", 1, 1, 10, 15, 15, 15, 0, 0, 0, 1);
    doReset();
    for (int i = 0; i < MEM_WAIT_MAX; i++)
      applyStimulus("wait_post_rst", 1, 1, 10, 15, 15, 15, 0, 0, 0, 1);
    applyStimulus("wait_post_done", 1, 1, 1, 15, 15, 15, 0, 0, 0, 0);

    $display("[TB] writeback exception halt and async reset");
    applyStimulus("wstat", 1, 1, 1, 15, 15, 15, 0, 0, 2, 0);
    for (int i = 0; i < 3; i++)
      applyStimulus("halted", 1, 6, 1, 15, 15, 15, 0, 0, 0, 0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_halted", 32'(halted), 32'd0);
    checkOutput("async_rst_timeout", 32'(mem_timeout), 32'd0);
    driveIdle();
    modelReset();
    @(negedge clk);
    rst = 1'b0;
    applyStimulus("run_after_halt", 1, 6, 1, 15, 15, 15, 0, 0, 0, 0);

    $display("[TB] writeback exception coinciding with timeout");
    for (int i = 0; i < MEM_WAIT_MAX; i++)
      applyStimulus("coinc_wait", 1, 1, 4, 15, 15, 15, 0, 0, 0, 1);
    applyStimulus("coinc_edge", 1, 1, 4, 15, 15, 15, 0, 0, 2, 1);
    applyStimulus("coinc_halt", 1, 1, 1, 15, 15, 15, 0, 0, 0, 0);
    applyStimulus("coinc_hold", 1, 1, 1, 15, 15, 15, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have the parameters below; one per line: name, default, meaning.
- REG_W, 4, register-ID width; all-ones encodes RNONE
- MEM_WAIT_MAX, 3, maximum data-memory wait cycles tolerated before timeout (1..255)
- CNT_W, 16, performance-counter width
REQ-002 The block SHALL have the ports below; one per line: name, direction, width, meaning.
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- D_icode, E_icode, M_icode  in  4  stage icodes
- d_srcA, d_srcB  in  REG_W  decode source registers
- E_dstM  in  REG_W  execute-stage load destination
- e_Cnd  in  1  branch taken
- m_stat, W_stat  in  2  status; 0=AOK, 1..3 = HLT/ADR/INS
- mem_busy  in  1  data memory not ready this cycle
- F_stall, D_stall, E_stall, M_stall, W_stall  out  1  hold stage register
- D_bubble, E_bubble, M_bubble, W_bubble  out  1  inject nop
- set_cc  out  1  condition-code write enable
- halted  out  1  sticky halt indicator
- mem_timeout  out  1  sticky timeout flag
- loaduse_cnt, mispredict_cnt  out  CNT_W  performance counters

Function
REQ-003 Icode encodings SHALL be: RMMOVQ=4, MRMOVQ=5, OPQ=6, JXX=7, CALL=8, RET=9, PUSHQ=10, POPQ=11.
REQ-004 The FSM SHALL have states RUN, MEMWAIT, HALT; all control outputs SHALL be combinational from state and inputs.
REQ-005 memop SHALL be M_icode in {4,5,8,9,10,11}; memstall SHALL be memop && mem_busy && state!=HALT.
REQ-006 loaduse SHALL be E_icode in {5,11} && E_dstM!=RNONE && (E_dstM==d_srcA || E_dstM==d_srcB).
REQ-007 mispredict SHALL be E_icode==JXX && !e_Cnd; retpend SHALL be RET in D, E or M.
REQ-008 exc SHALL be m_stat!=0 || W_stat!=0.
REQ-009 Priority, highest first: HALT, memstall, exc, loaduse, mispredict, retpend; unlisted outputs SHALL be 0.
- HALT: F_stall, D_stall, E_stall, M_bubble, W_stall = 1
- memstall: F_stall, D_stall, E_stall, M_stall = 1, W_bubble = 1
- exc: M_bubble = 1; W_stall = (W_stat!=0); loaduse/mispredict/retpend terms also apply
- loaduse: F_stall, D_stall, E_bubble = 1 (D_bubble suppressed even if retpend)
- mispredict: D_bubble, E_bubble = 1; F_stall = retpend
- retpend: F_stall, D_bubble = 1
REQ-010 set_cc SHALL be 1 only when E_icode==OPQ && !exc && !memstall && state==RUN.
REQ-011 Transitions: RUN->MEMWAIT on memstall; MEMWAIT->RUN when memstall deasserts; any state->HALT when W_stat!=0 at a clock edge; HALT is absorbing until reset.
REQ-012 wait_cnt SHALL increment on each edge with memstall and clear on each edge without it.
REQ-013 memstall with wait_cnt==MEM_WAIT_MAX SHALL, at that edge, enter HALT and set mem_timeout; MEM_WAIT_MAX busy cycles therefore never time out.
REQ-014 halted SHALL equal (state==HALT).
REQ-015 W_stat!=0 coinciding with a timeout SHALL enter HALT exactly once, with mem_timeout set.

Reset
REQ-016 rst SHALL asynchronously force state=RUN, wait_cnt=0, halted=0, mem_timeout=0 and counters=0.
REQ-017 rst asserted mid-MEMWAIT or in HALT SHALL abandon the wait without a timeout; after release, outputs SHALL follow REQ-009 from RUN on the first cycle.

Configuration
REQ-018 With PIPE_HZD_PERF_EN defined, loaduse_cnt and mispredict_cnt SHALL count edges with loaduse (respectively mispredict) asserted as that row's priority winner, saturating at all-ones.
REQ-019 Without PIPE_HZD_PERF_EN, both counter ports SHALL remain present and be tied to 0.

Verification
REQ-020 E_icode=5, E_dstM=3, d_srcA=3 -> F_stall=1, D_stall=1, E_bubble=1, D_bubble=0; with E_dstM=15 -> all outputs 0.
REQ-021 E_icode=7, e_Cnd=0, D_icode=9 -> D_bubble=1, E_bubble=1, F_stall=1; with e_Cnd=1 -> F_stall=1, D_bubble=1, E_bubble=0.
REQ-022 M_icode=5, mem_busy high 3 cycles -> F/D/E/M_stall=1 and W_bubble=1 for 3 cycles, then RUN with mem_timeout=0; mem_busy high 4 cycles -> halted=1 and mem_timeout=1 after the 4th edge.
REQ-023 W_stat=2 for one edge, then 0 -> halted=1 stays set, W_stall=1, M_bubble=1, set_cc=0 until rst; rst -> halted=0 immediately, without waiting for a clock edge.
REQ-024 With PIPE_HZD_PERF_EN and CNT_W=2, 5 load-use cycles -> loaduse_cnt=3 (saturated); without the macro -> loaduse_cnt=0.
